soc_reset_sequencer: RTL and testbench
======================================

// Module: soc_reset_sequencer
// PURPOSE
// - Sits between the MMCM and riscv_soc on the FPGA: consumes the MMCM locked flag, produces ordered resets and fetch enable.
// - Filters lock: locked must be stable before any release.
// - Release order: peripherals, then core, then instruction fetch. Any loss of lock re-arms the whole sequence.
// PARAMETERS
// - LOCK_CYCLES     16  cycles locked must stay high before periph release (>=1)
// - CORE_DELAY       8  cycles from periph reset release to core reset release (>=1)
// - FETCH_DELAY      4  cycles from core reset release to fetch_enable_o high (>=1)
// - SW_HOLD_CYCLES  32  reset hold length after a software request; used only with SOC_RST_SWREQ_EN (>=1)
// PORTS
// - clk_sys           in   1  free-running board clock, not MMCM-derived
// - reset             in   1  asynchronous, active-high reset
// - locked_i          in   1  MMCM locked, asynchronous to clk_sys
// - sw_reset_req_i    in   1  1-cycle request pulse, clk_sys domain; port exists only with SOC_RST_SWREQ_EN
// - periph_reset_n_o  out  1  active-low peripheral reset
// - core_reset_n_o    out  1  active-low core reset
// - fetch_enable_o    out  1  core fetch enable
// - seq_done_o        out  1  high while in RUN
// - state_o           out  3  current FSM state encoding, for debug/LED
// BEHAVIOUR
// - Reset: async assert, sync release. All outputs are 0, state_o=0 (WAIT_LOCK), both sync flops 0, counter 0.
// - locked_i passes through a 2-flop synchronizer; locked_s is the second flop.
// - Counter: clog2(max param)+1 bits; cleared on every state change, +1 per cycle inside a timed state.
// - Outputs are flops loaded from the next state on the same edge as the state register. No combinational glitches.
// - States, with the outputs they drive:
//   - WAIT_LOCK=0: all resets asserted, fetch 0.
//   - STABLE=1: as WAIT_LOCK.
//   - PERIPH=2: periph_reset_n_o=1.
//   - CORE=3: periph and core released.
//   - RUN=4: also fetch_enable_o=1 and seq_done_o=1.
//   - HOLD=5: as WAIT_LOCK.
// - Transitions:
//   - WAIT_LOCK -> STABLE when locked_s=1.
//   - STABLE -> PERIPH when cnt==LOCK_CYCLES-1 with locked_s=1.
//   - PERIPH -> CORE when cnt==CORE_DELAY-1.
//   - CORE -> RUN when cnt==FETCH_DELAY-1.
//   - RUN holds.
// - Lock loss: locked_s=0 in STABLE/PERIPH/CORE/RUN -> WAIT_LOCK next edge. All outputs are re-asserted on that edge and the counter is cleared.
// - Timing: locked_i high at edge N -> STABLE after N+2 -> periph release after N+2+LOCK_CYCLES.
//   - Core releases CORE_DELAY later; fetch goes high FETCH_DELAY after that.
//   - Defaults: edges N+18, N+26, N+30.
// - Lock glitch shorter than the 2-flop window may be missed. A glitch seen by locked_s always restarts from WAIT_LOCK.
// - Lock loss takes priority over the software request when both occur in the same cycle.
// - Reset mid-sequence: immediate async return to the reset values, regardless of state.
// CONFIGURATION
// - SOC_RST_SWREQ_EN defined:
//   - sw_reset_req_i present.
//   - A pulse in any state except WAIT_LOCK/HOLD -> HOLD next edge, all outputs asserted.
//   - HOLD -> WAIT_LOCK at cnt==SW_HOLD_CYCLES-1, then the normal sequence runs.
//   - A pulse while already in HOLD or WAIT_LOCK is ignored.
// - SOC_RST_SWREQ_EN undefined:
//   - sw_reset_req_i port absent; HOLD state and SW_HOLD_CYCLES logic not built.
//   - state_o never reads 5.
// TESTING
// - Reset held, locked_i=1 -> all outputs 0, state_o=0; release reset -> defaults give periph/core/fetch high at edges +18/+26/+30 after first sample.
// - locked_i=1, then 0 for 3 cycles at STABLE cnt=10 -> back to WAIT_LOCK, counter restarts. Periph release 16 cycles after locked_s re-rises.
// - In RUN, locked_i=0 -> fetch_enable_o, core_reset_n_o, periph_reset_n_o, seq_done_o all 0 two edges after the drop; state_o=0.
// - reset pulsed mid-CORE -> outputs 0 asynchronously, before the next clk_sys edge. Sequence restarts from WAIT_LOCK.
// - SOC_RST_SWREQ_EN: in RUN, pulse sw_reset_req_i -> state_o=5 for 32 cycles with all resets asserted, then full re-sequence. A second pulse during HOLD has no effect.
// - Params LOCK_CYCLES=1, CORE_DELAY=1, FETCH_DELAY=1 -> periph/core/fetch release on 3 consecutive edges; no state skipped.

Source files
------------

// File: rtl/soc_reset_sequencer.sv
// Reset sequencer between the MMCM and riscv_soc: filters MMCM lock, then releases peripherals, core and fetch in order.
// Optional build macro SOC_RST_SWREQ_EN adds sw_reset_req_i and the HOLD state.
module soc_reset_sequencer #(
  parameter int unsigned LOCK_CYCLES    = 16,
  parameter int unsigned CORE_DELAY     = 8,
  parameter int unsigned FETCH_DELAY    = 4,
  parameter int unsigned SW_HOLD_CYCLES = 32
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       locked_i,
`ifdef SOC_RST_SWREQ_EN
  input  logic       sw_reset_req_i,
`endif
  output logic       periph_reset_n_o,
  output logic       core_reset_n_o,
  output logic       fetch_enable_o,
  output logic       seq_done_o,
  output logic [2:0] state_o
);

  localparam int unsigned MAX_AB  = (LOCK_CYCLES > CORE_DELAY) ? LOCK_CYCLES : CORE_DELAY;
  localparam int unsigned MAX_CD  = (FETCH_DELAY > SW_HOLD_CYCLES) ? FETCH_DELAY : SW_HOLD_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL) + 1;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST  = CNT_W'(CORE_DELAY - 1);
  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_DELAY - 1);
`ifdef SOC_RST_SWREQ_EN
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SW_HOLD_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    PERIPH    = 3'd2,
    CORE      = 3'd3,
    RUN       = 3'd4
`ifdef SOC_RST_SWREQ_EN
    ,
    HOLD      = 3'd5
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic             periph_q, core_q, run_q;
  logic             periph_d, core_d, run_d;
  logic             timed;

  // Two-flop synchronizer; locked_i comes from the MMCM, unrelated to clk_sys.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], locked_i};
    end
  end

  assign locked_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    timed   = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) state_d = STABLE;
      end
      STABLE: begin
        timed = 1'b1;
        if (!locked_s)               state_d = WAIT_LOCK;
        else if (cnt_q == LOCK_LAST) state_d = PERIPH;
      end
      PERIPH: begin
        timed = 1'b1;
        if (!locked_s)               state_d = WAIT_LOCK;
        else if (cnt_q == CORE_LAST) state_d = CORE;
      end
      CORE: begin
        timed = 1'b1;
        if (!locked_s)                state_d = WAIT_LOCK;
        else if (cnt_q == FETCH_LAST) state_d = RUN;
      end
      RUN: begin
        if (!locked_s) state_d = WAIT_LOCK;
      end
`ifdef SOC_RST_SWREQ_EN
      HOLD: begin
        timed = 1'b1;
        if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
      end
`endif
      default: state_d = WAIT_LOCK;
    endcase
`ifdef SOC_RST_SWREQ_EN
    // Lock loss outranks the request: locked_s gates entry to HOLD.
    if (sw_reset_req_i && locked_s &&
        (state_q inside {STABLE, PERIPH, CORE, RUN})) begin
      state_d = HOLD;
    end
`endif
  end

  always_comb begin
    cnt_d = '0;
    if (state_d == state_q && timed) cnt_d = cnt_q + 1'b1;
    periph_d = (state_d == PERIPH) || (state_d == CORE) || (state_d == RUN);
    core_d   = (state_d == CORE) || (state_d == RUN);
    run_d    = (state_d == RUN);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      core_q   <= core_d;
      run_q    <= run_d;
    end
  end

  assign periph_reset_n_o = periph_q;
  assign core_reset_n_o   = core_q;
  assign fetch_enable_o   = run_q;
  assign seq_done_o       = run_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Bench for soc_reset_sequencer: default-parameter and minimum-parameter instances checked every cycle
// against a lock-streak model, plus literal release-edge checks. Honours SOC_RST_SWREQ_EN when defined.
module tb_soc_reset_sequencer;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       locked_i = 1'b0;
  logic       sw_req = 1'b0;
  logic [1:0] periph_n, core_n, fetch_en, done;
  logic [2:0] st0, st1;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned p_lock [2] = '{16, 1};
  int unsigned p_core [2] = '{8, 1};
  int unsigned p_fetch[2] = '{4, 1};
  int unsigned p_hold [2] = '{32, 3};

  always #5 clk_sys = ~clk_sys;

  soc_reset_sequencer #(
    .LOCK_CYCLES(16), .CORE_DELAY(8), .FETCH_DELAY(4), .SW_HOLD_CYCLES(32)
  ) dut_def (
    .clk_sys(clk_sys), .reset(reset), .locked_i(locked_i),
`ifdef SOC_RST_SWREQ_EN
    .sw_reset_req_i(sw_req),
`endif
    .periph_reset_n_o(periph_n[0]), .core_reset_n_o(core_n[0]),
    .fetch_enable_o(fetch_en[0]), .seq_done_o(done[0]), .state_o(st0)
  );

  soc_reset_sequencer #(
    .LOCK_CYCLES(1), .CORE_DELAY(1), .FETCH_DELAY(1), .SW_HOLD_CYCLES(3)
  ) dut_min (
    .clk_sys(clk_sys), .reset(reset), .locked_i(locked_i),
`ifdef SOC_RST_SWREQ_EN
    .sw_reset_req_i(sw_req),
`endif
    .periph_reset_n_o(periph_n[1]), .core_reset_n_o(core_n[1]),
    .fetch_enable_o(fetch_en[1]), .seq_done_o(done[1]), .state_o(st1)
  );

  // Model: k = consecutive edges that saw synchronized lock high since the last restart.
  // The phase follows from k against cumulative delay thresholds.
  bit          s1 = 1'b0, s2 = 1'b0;
  int unsigned m_k [2] = '{0, 0};
  bit          m_hold [2] = '{1'b0, 1'b0};
  int unsigned m_hn [2] = '{0, 0};

  initial forever begin
    bit ls;
    @(posedge clk_sys or posedge reset);
    if (reset) begin
      s1 = 1'b0; s2 = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_k[i] = 0; m_hold[i] = 1'b0; m_hn[i] = 0;
      end
    end else begin
      ls = s2; s2 = s1; s1 = locked_i;
      for (int i = 0; i < 2; i++) begin
        if (m_hold[i]) begin
          m_hn[i]++;
          if (m_hn[i] == p_hold[i]) begin m_hold[i] = 1'b0; m_k[i] = 0; end
        end else if (m_k[i] != 0 && !ls) begin
          m_k[i] = 0;
        end else if (m_k[i] != 0 && sw_req) begin
          m_hold[i] = 1'b1; m_hn[i] = 0; m_k[i] = 0;
        end else if (ls && m_k[i] < 1 + p_lock[i] + p_core[i] + p_fetch[i]) begin
          m_k[i]++;
        end
      end
    end
  end

  function automatic logic [2:0] exp_state(input int i);
    if (m_hold[i]) return 3'd5;
    if (m_k[i] == 0) return 3'd0;
    if (m_k[i] <= p_lock[i]) return 3'd1;
    if (m_k[i] <= p_lock[i] + p_core[i]) return 3'd2;
    if (m_k[i] <= p_lock[i] + p_core[i] + p_fetch[i]) return 3'd3;
    return 3'd4;
  endfunction

  function automatic logic [6:0] exp_outs(input int i);
    logic [2:0] s;
    s = exp_state(i);
    return {(s >= 3'd2 && s <= 3'd4), (s == 3'd3 || s == 3'd4), (s == 3'd4), (s == 3'd4), s};
  endfunction

  function automatic logic [6:0] dut_outs(input int i);
    return {periph_n[i], core_n[i], fetch_en[i], done[i], (i == 0) ? st0 : st1};
  endfunction

  initial forever begin
    @(negedge clk_sys);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (dut_outs(i) !== exp_outs(i)) begin
        n_fail++;
        $display("FAIL model_cmp inst%0d t=%0t got {p,c,f,d,st}=%b expected %b", i, $time, dut_outs(i), exp_outs(i));
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  int rise_p [2], rise_c [2], rise_f [2];

  // Edge 1 is the first posedge after the call; records first edge each output reads high.
  task automatic measure(input int unsigned nedges);
    for (int i = 0; i < 2; i++) begin rise_p[i] = -1; rise_c[i] = -1; rise_f[i] = -1; end
    for (int e = 1; e <= int'(nedges); e++) begin
      @(posedge clk_sys); #1;
      for (int i = 0; i < 2; i++) begin
        if (periph_n[i] && rise_p[i] < 0) rise_p[i] = e;
        if (core_n[i]   && rise_c[i] < 0) rise_c[i] = e;
        if (fetch_en[i] && rise_f[i] < 0) rise_f[i] = e;
      end
    end
  endtask

  initial begin
    int hold_edges;
    int unsigned run_left;
    bit lvl;

    reset = 1'b1;
    locked_i = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_outs_def", int'(dut_outs(0)), 0);
    check("reset_outs_min", int'(dut_outs(1)), 0);

    #1 reset = 1'b0;
    measure(35);
    check("def_periph_edge", rise_p[0], 19);
    check("def_core_edge",   rise_c[0], 27);
    check("def_fetch_edge",  rise_f[0], 31);
    check("min_periph_edge", rise_p[1], 4);
    check("min_core_edge",   rise_c[1], 5);
    check("min_fetch_edge",  rise_f[1], 6);
    check("def_run_state",   int'(st0), 4);

    // Lock loss in RUN: sampled on the first edge, outputs drop two edges later.
    @(posedge clk_sys); #2 locked_i = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1 check("run_drop_fetch_still_high", int'(fetch_en[0]), 1);
    @(posedge clk_sys);
    #1 check("run_drop_outs_def", int'(dut_outs(0)), 0);

    // Relock, then glitch while STABLE cnt=10.
    @(posedge clk_sys); #2 locked_i = 1'b1;
    repeat (13) @(posedge clk_sys);
    #2 locked_i = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1 check("glitch_back_to_wait", int'(st0), 0);
    #1 locked_i = 1'b1;
    measure(35);
    check("glitch_relock_periph_edge", rise_p[0], 19);

    // Async reset in the middle of CORE.
    @(posedge clk_sys); #2 locked_i = 1'b0;
    repeat (4) @(posedge clk_sys);
    #2 locked_i = 1'b1;
    repeat (28) @(posedge clk_sys);
    #1 check("pre_reset_in_core", int'(st0), 3);
    #1 reset = 1'b1;
    #1;
    check("async_reset_outs_def", int'(dut_outs(0)), 0);
    check("async_reset_outs_min", int'(dut_outs(1)), 0);
    @(posedge clk_sys); #2 reset = 1'b0;
    measure(35);
    check("post_reset_periph_edge", rise_p[0], 19);

`ifdef SOC_RST_SWREQ_EN
    // Software request in RUN, with a second ignored pulse during HOLD.
    hold_edges = 0;
    @(posedge clk_sys); #2 sw_req = 1'b1;
    for (int e = 0; e < 50; e++) begin
      @(posedge clk_sys); #1;
      if (st0 == 3'd5) hold_edges++;
      #1 sw_req = (e == 10);
    end
    check("sw_hold_edges", hold_edges, 32);
    measure(35);
    check("sw_resequence_fetch", int'(fetch_en[0]), 1);
`endif

    // Randomized lock behaviour with rare resets and software requests.
    run_left = 0;
    lvl = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_sys); #2;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 399) == 0) reset = 1'b1;
      if (run_left == 0) begin
        lvl = !lvl;
        run_left = lvl ? $urandom_range(1, 45) : $urandom_range(1, 5);
      end
      run_left--;
      locked_i = lvl;
`ifdef SOC_RST_SWREQ_EN
      sw_req = ($urandom_range(0, 29) == 0);
`endif
    end
    reset = 1'b0;
    sw_req = 1'b0;
    repeat (4) @(posedge clk_sys);
    #6;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
